shift_sequencer: RTL and testbench

- Multi-cycle controller that sequences the team's single-step `shifter` datapath to perform shifts of 0-15 positions on a 16-bit operand.
- Accepts one request at a time via a start/busy/done handshake.
- Iterates the 1-bit shifter once per clock and holds the final result for the register-file writeback path.

---
 rtl/shift_seq_pkg.sv | 18 +
 rtl/shifter.sv | 20 ++
 rtl/shift_sequencer.sv | 84 ++++++++
 tb/tb_shift_sequencer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer and its 1-bit shifter datapath.
package shift_seq_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [1:0] SH_PASS = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/shifter.sv
// Single-step shifter datapath: one bit of LSL/LSR/ASR, or pass-through.
module shifter
    import shift_seq_pkg::*;
(
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       shift,
    output logic [WIDTH-1:0] sout
);

    always_comb begin
        sout = in;
        case (shift)
            SH_LSL:  sout = {in[WIDTH-2:0], 1'b0};
            SH_LSR:  sout = {1'b0, in[WIDTH-1:1]};
            SH_ASR:  sout = {in[WIDTH-1], in[WIDTH-1:1]};
            default: sout = in;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Iterates the 1-bit shifter once per clock to shift a 16-bit operand by 0-15 positions.
// Optional: SHIFT_SEQ_EARLY_EXIT_EN finishes as soon as the accumulator reaches a fixed point.
module shift_sequencer
    import shift_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       shift,
    input  logic [CNT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_e             state_reg, state_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [1:0]         op_reg, op_next;
    logic [WIDTH-1:0]   result_reg;
    logic [WIDTH-1:0]   sout;

    shifter u_shifter (
        .in    (acc_reg),
        .shift (op_reg),
        .sout  (sout)
    );

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    acc_next   = in;
                    op_next    = shift;
                    cnt_next   = amount;
                    state_next = (amount == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                acc_next = sout;
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = DONE;
                end
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
                if (sout == acc_reg) begin
                    state_next = DONE;
                end
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // result is loaded on entry to DONE so it is already valid while done is high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            op_reg     <= SH_PASS;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            if (state_next == DONE) begin
                result_reg <= acc_next;
            end
        end
    end

    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign result = result_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed-vector bench for shift_sequencer; expected latencies follow SHIFT_SEQ_EARLY_EXIT_EN.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] in;
    logic [1:0]  shift;
    logic [3:0]  amount;
    logic        busy;
    logic        done;
    logic [15:0] result;

    int n_compared   = 0;
    int n_mismatched = 0;

    shift_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .in     (in),
        .shift  (shift),
        .amount (amount),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start in cycle 0, then observe cycles 1..24; glitch>0 pulses a stray start (in=FFFF, amount=1) in that cycle.
    task automatic run_op(input string tag, input logic [15:0] din, input logic [1:0] sh,
                          input logic [3:0] amt, input int exp_cyc, input logic [15:0] exp_res,
                          input int glitch);
        int          done_cyc = -1;
        int          npulse   = 0;
        int          nbusy    = 0;
        logic [15:0] res_at   = '0;
        @(negedge clk);
        start  = 1'b1;
        in     = din;
        shift  = sh;
        amount = amt;
        @(posedge clk); #1;
        for (int k = 1; k <= 24; k++) begin
            if (k == glitch) begin
                start  = 1'b1;
                in     = 16'hFFFF;
                amount = 4'd1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                npulse++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    res_at   = result;
                end
            end
            if (busy) nbusy++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({tag, " done_cycle"}, done_cyc, exp_cyc);
        check({tag, " done_pulses"}, npulse, 1);
        check({tag, " busy_cycles"}, nbusy, exp_cyc);
        check({tag, " result"}, {16'h0, res_at}, {16'h0, exp_res});
        check({tag, " result_held"}, {16'h0, result}, {16'h0, exp_res});
        $display("op %s: in=%h shift=%b amount=%0d done_cycle=%0d result=%h", tag, din, sh, amt, done_cyc, res_at);
    endtask

    initial begin
        int ndone;
        reset  = 1'b1;
        start  = 1'b0;
        in     = '0;
        shift  = '0;
        amount = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'h0, busy}, 0);
        check("reset done", {31'h0, done}, 0);
        check("reset result", {16'h0, result}, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op("lsl4", 16'h0001, 2'b01, 4'd4, 5, 16'h0010, 0);
        run_op("asr3", 16'h8000, 2'b11, 4'd3, 4, 16'hF000, 0);
        run_op("amt0", 16'h1234, 2'b10, 4'd0, 1, 16'h1234, 0);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        run_op("lsr15", 16'h00F0, 2'b10, 4'd15, 10, 16'h0000, 0);
        run_op("pass5", 16'hABCD, 2'b00, 4'd5, 2, 16'hABCD, 0);
`else
        run_op("lsr15", 16'h00F0, 2'b10, 4'd15, 16, 16'h0000, 0);
        run_op("pass5", 16'hABCD, 2'b00, 4'd5, 6, 16'hABCD, 0);
`endif
        run_op("ignore_start", 16'h0003, 2'b01, 4'd6, 7, 16'h00C0, 2);

        // Abort mid-operation with an asynchronous reset in cycle 4
        @(negedge clk);
        start  = 1'b1;
        in     = 16'h0001;
        shift  = 2'b01;
        amount = 4'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("abort busy", {31'h0, busy}, 0);
        check("abort done", {31'h0, done}, 0);
        check("abort result", {16'h0, result}, 0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("abort no_done", ndone, 0);
        $display("op abort: reset in cycle 4, activity after release=%0d", ndone);

        run_op("after_abort", 16'h0002, 2'b10, 4'd1, 2, 16'h0001, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
